// File: rtl/axil_rr_arbiter.sv
// rtl/axil_rr_arbiter.sv - two-requester AXI-lite round-robin arbiter onto one downstream port
module axil_rr_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RESP_WIDTH = 3,
    parameter int STRB_WIDTH = DATA_WIDTH / 8 + 1
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,

    input  logic [ADDR_WIDTH-1:0] r0_awaddr,
    input  logic                  r0_awvalid,
    output logic                  r0_awready,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic [STRB_WIDTH-1:0] r0_wstrb,
    input  logic                  r0_wvalid,
    output logic                  r0_wready,
    output logic [RESP_WIDTH-1:0] r0_bresp,
    output logic                  r0_bvalid,
    input  logic                  r0_bready,
    input  logic [ADDR_WIDTH-1:0] r0_araddr,
    input  logic                  r0_arvalid,
    output logic                  r0_arready,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    output logic [RESP_WIDTH-1:0] r0_rresp,
    output logic                  r0_rvalid,
    input  logic                  r0_rready,

    input  logic [ADDR_WIDTH-1:0] r1_awaddr,
    input  logic                  r1_awvalid,
    output logic                  r1_awready,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    input  logic [STRB_WIDTH-1:0] r1_wstrb,
    input  logic                  r1_wvalid,
    output logic                  r1_wready,
    output logic [RESP_WIDTH-1:0] r1_bresp,
    output logic                  r1_bvalid,
    input  logic                  r1_bready,
    input  logic [ADDR_WIDTH-1:0] r1_araddr,
    input  logic                  r1_arvalid,
    output logic                  r1_arready,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic [RESP_WIDTH-1:0] r1_rresp,
    output logic                  r1_rvalid,
    input  logic                  r1_rready,

    output logic [ADDR_WIDTH-1:0] m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [STRB_WIDTH-1:0] m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [RESP_WIDTH-1:0] m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic [ADDR_WIDTH-1:0] m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic [RESP_WIDTH-1:0] m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready,

    output logic                  busy,
    output logic                  grant
);

    typedef enum logic [3:0] {
        IDLE,
        W_ACC,
        W_ISSUE,
        W_RESP,
        W_RET,
        R_ACC,
        R_ISSUE,
        R_RESP,
        R_RET
    } state_t;

    state_t state_q, state_d;

    logic                  grant_q;
    logic                  last_grant_q;
    logic [1:0]            pref_rd_q;
    logic                  aw_done_q;
    logic                  w_done_q;
    logic [ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0] w_data_q;
    logic [STRB_WIDTH-1:0] w_strb_q;
    logic [ADDR_WIDTH-1:0] ar_addr_q;
    logic [RESP_WIDTH-1:0] b_resp_q;
    logic [DATA_WIDTH-1:0] r_data_q;
    logic [RESP_WIDTH-1:0] r_resp_q;

    logic req_w0, req_r0, req_w1, req_r1;
    logic req0, req1, any_req;
    logic win, win_w, win_r, win_is_read;
    logic bready_sel, rready_sel;

    assign req_w0  = r0_awvalid & r0_wvalid;
    assign req_r0  = r0_arvalid;
    assign req_w1  = r1_awvalid & r1_wvalid;
    assign req_r1  = r1_arvalid;
    assign req0    = req_w0 | req_r0;
    assign req1    = req_w1 | req_r1;
    assign any_req = req0 | req1;

    // On contention the requester that did not win last time goes next.
    assign win         = (req0 & req1) ? ~last_grant_q : req1;
    assign win_w       = win ? req_w1 : req_w0;
    assign win_r       = win ? req_r1 : req_r0;
    assign win_is_read = (win_w & win_r) ? pref_rd_q[win] : win_r;

    assign bready_sel = grant_q ? r1_bready : r0_bready;
    assign rready_sel = grant_q ? r1_rready : r0_rready;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = win_is_read ? R_ACC : W_ACC;
                end
            end
            W_ACC:   state_d = W_ISSUE;
            W_ISSUE: begin
                if ((aw_done_q | m_awready) & (w_done_q | m_wready)) begin
                    state_d = W_RESP;
                end
            end
            W_RESP:  if (m_bvalid) state_d = W_RET;
            W_RET:   if (bready_sel) state_d = IDLE;
            R_ACC:   state_d = R_ISSUE;
            R_ISSUE: if (m_arready) state_d = R_RESP;
            R_RESP:  if (m_rvalid) state_d = R_RET;
            R_RET:   if (rready_sel) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            pref_rd_q    <= 2'b00;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
            aw_addr_q    <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            ar_addr_q    <= '0;
            b_resp_q     <= '0;
            r_data_q     <= '0;
            r_resp_q     <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q         <= win;
                        last_grant_q    <= win;
                        pref_rd_q[win]  <= ~win_is_read;
                    end
                end
                W_ACC: begin
                    aw_addr_q <= grant_q ? r1_awaddr : r0_awaddr;
                    w_data_q  <= grant_q ? r1_wdata  : r0_wdata;
                    w_strb_q  <= grant_q ? r1_wstrb  : r0_wstrb;
                    aw_done_q <= 1'b0;
                    w_done_q  <= 1'b0;
                end
                W_ISSUE: begin
                    if (m_awready) aw_done_q <= 1'b1;
                    if (m_wready)  w_done_q  <= 1'b1;
                end
                W_RESP: begin
                    if (m_bvalid) b_resp_q <= m_bresp;
                end
                R_ACC: begin
                    ar_addr_q <= grant_q ? r1_araddr : r0_araddr;
                end
                R_RESP: begin
                    if (m_rvalid) begin
                        r_data_q <= m_rdata;
                        r_resp_q <= m_rresp;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Every handshake output is a pure decode of registered state.
    assign r0_awready = (state_q == W_ACC) & ~grant_q;
    assign r0_wready  = (state_q == W_ACC) & ~grant_q;
    assign r0_arready = (state_q == R_ACC) & ~grant_q;
    assign r0_bvalid  = (state_q == W_RET) & ~grant_q;
    assign r0_rvalid  = (state_q == R_RET) & ~grant_q;
    assign r0_bresp   = r0_bvalid ? b_resp_q : '0;
    assign r0_rdata   = r0_rvalid ? r_data_q : '0;
    assign r0_rresp   = r0_rvalid ? r_resp_q : '0;

    assign r1_awready = (state_q == W_ACC) & grant_q;
    assign r1_wready  = (state_q == W_ACC) & grant_q;
    assign r1_arready = (state_q == R_ACC) & grant_q;
    assign r1_bvalid  = (state_q == W_RET) & grant_q;
    assign r1_rvalid  = (state_q == R_RET) & grant_q;
    assign r1_bresp   = r1_bvalid ? b_resp_q : '0;
    assign r1_rdata   = r1_rvalid ? r_data_q : '0;
    assign r1_rresp   = r1_rvalid ? r_resp_q : '0;

    assign m_awaddr  = aw_addr_q;
    assign m_awvalid = (state_q == W_ISSUE) & ~aw_done_q;
    assign m_wdata   = w_data_q;
    assign m_wstrb   = w_strb_q;
    assign m_wvalid  = (state_q == W_ISSUE) & ~w_done_q;
    assign m_bready  = (state_q == W_RESP);
    assign m_araddr  = ar_addr_q;
    assign m_arvalid = (state_q == R_ISSUE);
    assign m_rready  = (state_q == R_RESP);

    assign busy  = (state_q != IDLE);
    assign grant = grant_q;

endmodule

// File: tb/tb_axil_rr_arbiter.sv
// tb/tb_axil_rr_arbiter.sv - directed table-driven bench for axil_rr_arbiter
module tb_axil_rr_arbiter;

    localparam int DW = 32;
    localparam int AW = 8;
    localparam int RW = 3;
    localparam int SW = DW / 8 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rstn;

    logic [1:0]         awvalid, wvalid, bready, arvalid, rready;
    logic [1:0][AW-1:0] awaddr, araddr;
    logic [1:0][DW-1:0] wdata;
    logic [1:0][SW-1:0] wstrb;

    logic          r0_awready, r0_wready, r0_bvalid, r0_arready, r0_rvalid;
    logic          r1_awready, r1_wready, r1_bvalid, r1_arready, r1_rvalid;
    logic [RW-1:0] r0_bresp, r0_rresp, r1_bresp, r1_rresp;
    logic [DW-1:0] r0_rdata, r1_rdata;

    logic [AW-1:0] m_awaddr, m_araddr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [SW-1:0] m_wstrb;
    logic [RW-1:0] m_bresp, m_rresp;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic m_arvalid, m_arready, m_rvalid, m_rready;
    logic busy, grant;

    logic [1:0]         awready_v, wready_v, arready_v, bvalid_v, rvalid_v;
    logic [1:0][RW-1:0] bresp_v, rresp_v;
    logic [1:0][DW-1:0] rdata_v;

    assign awready_v = {r1_awready, r0_awready};
    assign wready_v  = {r1_wready, r0_wready};
    assign arready_v = {r1_arready, r0_arready};
    assign bvalid_v  = {r1_bvalid, r0_bvalid};
    assign rvalid_v  = {r1_rvalid, r0_rvalid};
    assign bresp_v   = {r1_bresp, r0_bresp};
    assign rresp_v   = {r1_rresp, r0_rresp};
    assign rdata_v   = {r1_rdata, r0_rdata};

    axil_rr_arbiter #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RESP_WIDTH(RW), .STRB_WIDTH(SW)
    ) dut (
        .axi_aclk(clk), .axi_aresetn(rstn),
        .r0_awaddr(awaddr[0]), .r0_awvalid(awvalid[0]), .r0_awready(r0_awready),
        .r0_wdata(wdata[0]), .r0_wstrb(wstrb[0]), .r0_wvalid(wvalid[0]), .r0_wready(r0_wready),
        .r0_bresp(r0_bresp), .r0_bvalid(r0_bvalid), .r0_bready(bready[0]),
        .r0_araddr(araddr[0]), .r0_arvalid(arvalid[0]), .r0_arready(r0_arready),
        .r0_rdata(r0_rdata), .r0_rresp(r0_rresp), .r0_rvalid(r0_rvalid), .r0_rready(rready[0]),
        .r1_awaddr(awaddr[1]), .r1_awvalid(awvalid[1]), .r1_awready(r1_awready),
        .r1_wdata(wdata[1]), .r1_wstrb(wstrb[1]), .r1_wvalid(wvalid[1]), .r1_wready(r1_wready),
        .r1_bresp(r1_bresp), .r1_bvalid(r1_bvalid), .r1_bready(bready[1]),
        .r1_araddr(araddr[1]), .r1_arvalid(arvalid[1]), .r1_arready(r1_arready),
        .r1_rdata(r1_rdata), .r1_rresp(r1_rresp), .r1_rvalid(r1_rvalid), .r1_rready(rready[1]),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .busy(busy), .grant(grant)
    );

    typedef struct {
        bit          req;
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [4:0]  strb;
        logic [2:0]  resp;
        logic [7:0]  exp_addr;
        logic [31:0] exp_data;
        logic [4:0]  exp_strb;
        logic [2:0]  exp_resp;
    } vec_t;

    vec_t vecs [5];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs;
        awvalid = '0; wvalid = '0; arvalid = '0;
    endtask

    task automatic run_txn(input int i, input vec_t v);
        int n;
        int o;
        n = v.req ? 1 : 0;
        o = 1 - n;
        m_bresp = v.resp; m_rresp = v.resp; m_rdata = v.data;
        if (v.wr) begin
            awvalid[n] = 1'b1; wvalid[n] = 1'b1;
            awaddr[n] = v.addr; wdata[n] = v.data; wstrb[n] = v.strb;
        end else begin
            arvalid[n] = 1'b1; araddr[n] = v.addr;
        end
        bready = 2'b11; rready = 2'b11;
        tick;
        chk($sformatf("v%0d grant", i), grant, v.req);
        if (v.wr) chk($sformatf("v%0d aw/w ready", i), {awready_v[n], wready_v[n]}, 2'b11);
        else      chk($sformatf("v%0d arready", i), arready_v[n], 1'b1);
        chk($sformatf("v%0d other ready", i), {awready_v[o], wready_v[o], arready_v[o]}, 3'b000);
        tick;
        clear_reqs();
        awaddr[n] = ~v.addr; wdata[n] = ~v.data; araddr[n] = ~v.addr;
        if (v.wr) begin
            chk($sformatf("v%0d m aw/w valid", i), {m_awvalid, m_wvalid}, 2'b11);
            chk($sformatf("v%0d m_awaddr", i), m_awaddr, v.exp_addr);
            chk($sformatf("v%0d m_wdata", i), m_wdata, v.exp_data);
            chk($sformatf("v%0d m_wstrb", i), m_wstrb, v.exp_strb);
        end else begin
            chk($sformatf("v%0d m_arvalid", i), m_arvalid, 1'b1);
            chk($sformatf("v%0d m_araddr", i), m_araddr, v.exp_addr);
        end
        tick;
        chk($sformatf("v%0d m resp ready", i), v.wr ? m_bready : m_rready, 1'b1);
        tick;
        if (v.wr) begin
            chk($sformatf("v%0d bvalid", i), bvalid_v, (n == 1) ? 2'b10 : 2'b01);
            chk($sformatf("v%0d bresp", i), bresp_v[n], v.exp_resp);
        end else begin
            chk($sformatf("v%0d rvalid", i), rvalid_v, (n == 1) ? 2'b10 : 2'b01);
            chk($sformatf("v%0d rdata", i), rdata_v[n], v.exp_data);
            chk($sformatf("v%0d rresp", i), rresp_v[n], v.exp_resp);
        end
        tick;
        chk($sformatf("v%0d idle after", i), busy, 1'b0);
    endtask

    task automatic pulse_reset;
        rstn = 1'b0;
        #2;
        chk("rst busy", busy, 1'b0);
        chk("rst grant", grant, 1'b0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not end, expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b0, 1'b1, 8'h04, 32'hDEADBEEF, 5'h0F, 3'd0, 8'h04, 32'hDEADBEEF, 5'h0F, 3'd0};
        vecs[1] = '{1'b1, 1'b0, 8'h20, 32'hCAFEF00D, 5'h00, 3'd2, 8'h20, 32'hCAFEF00D, 5'h00, 3'd2};
        vecs[2] = '{1'b1, 1'b1, 8'hFF, 32'h00000001, 5'h1F, 3'd5, 8'hFF, 32'h00000001, 5'h1F, 3'd5};
        vecs[3] = '{1'b0, 1'b0, 8'h00, 32'hFFFFFFFF, 5'h00, 3'd7, 8'h00, 32'hFFFFFFFF, 5'h00, 3'd7};
        vecs[4] = '{1'b0, 1'b1, 8'h80, 32'h12345678, 5'h10, 3'd1, 8'h80, 32'h12345678, 5'h10, 3'd1};

        rstn = 1'b0;
        clear_reqs();
        awaddr = '0; araddr = '0; wdata = '0; wstrb = '0; bready = '0; rready = '0;
        m_awready = 1'b1; m_wready = 1'b1; m_arready = 1'b1;
        m_bvalid = 1'b1; m_rvalid = 1'b1;
        m_bresp = '0; m_rresp = '0; m_rdata = '0;
        tick;
        tick;
        chk("reset busy", busy, 1'b0);
        chk("reset grant", grant, 1'b0);
        chk("reset readies", {awready_v, wready_v, arready_v}, 6'b0);
        chk("reset resp valids", {bvalid_v, rvalid_v}, 4'b0);
        chk("reset m valids", {m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}, 5'b0);
        chk("reset m data", {m_awaddr, m_araddr, m_wdata, m_wstrb}, 53'b0);
        rstn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            run_txn(i, vecs[i]);
        end

        // Simultaneous reads right after reset: r0 first, then r1, no cross delivery.
        pulse_reset();
        m_rdata = 32'h11111111; m_rresp = '0;
        arvalid = 2'b11; araddr[0] = 8'h08; araddr[1] = 8'h18; rready = 2'b11;
        tick;
        chk("cont grant0", grant, 1'b0);
        chk("cont arready0", arready_v, 2'b01);
        tick;
        arvalid[0] = 1'b0;
        chk("cont araddr0", m_araddr, 8'h08);
        tick;
        tick;
        chk("cont rvalid0", rvalid_v, 2'b01);
        chk("cont rdata0", rdata_v[0], 32'h11111111);
        chk("cont r1 rdata quiet", rdata_v[1], 32'h0);
        m_rdata = 32'h22222222;
        tick;
        chk("cont idle gap", busy, 1'b0);
        tick;
        chk("cont grant1", grant, 1'b1);
        chk("cont arready1", arready_v, 2'b10);
        tick;
        arvalid[1] = 1'b0;
        chk("cont araddr1", m_araddr, 8'h18);
        tick;
        tick;
        chk("cont rvalid1", rvalid_v, 2'b10);
        chk("cont rdata1", rdata_v[1], 32'h22222222);
        chk("cont r0 rdata quiet", rdata_v[0], 32'h0);
        tick;

        // r1 holding both write and read: W, R, W, R with one idle cycle between.
        pulse_reset();
        awvalid[1] = 1'b1; wvalid[1] = 1'b1; arvalid[1] = 1'b1;
        awaddr[1] = 8'h14; araddr[1] = 8'h1C; wdata[1] = 32'h0BADF00D; wstrb[1] = 5'h0F;
        bready = 2'b11; rready = 2'b11;
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("alt%0d awready", k), r1_awready, (k % 2 == 0) ? 1'b1 : 1'b0);
            chk($sformatf("alt%0d arready", k), r1_arready, (k % 2 == 1) ? 1'b1 : 1'b0);
            tick;
            if (k % 2 == 0) chk($sformatf("alt%0d m_awaddr", k), m_awaddr, 8'h14);
            else            chk($sformatf("alt%0d m_araddr", k), m_araddr, 8'h1C);
            tick;
            tick;
            chk($sformatf("alt%0d busy ret", k), busy, 1'b1);
            tick;
            chk($sformatf("alt%0d busy gap", k), busy, 1'b0);
        end
        clear_reqs();
        tick;
        chk("alt settled", busy, 1'b0);

        // Downstream aw and w handshakes in different cycles.
        m_awready = 1'b0; m_wready = 1'b0;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        awaddr[0] = 8'h30; wdata[0] = 32'hA5A5A5A5; wstrb[0] = 5'h03; bready[0] = 1'b1;
        tick;
        tick;
        clear_reqs();
        chk("split c2 valids", {m_awvalid, m_wvalid}, 2'b11);
        m_awready = 1'b1;
        tick;
        m_awready = 1'b0;
        chk("split c3 valids", {m_awvalid, m_wvalid}, 2'b01);
        chk("split c3 bready", m_bready, 1'b0);
        tick;
        chk("split c4 wvalid", m_wvalid, 1'b1);
        tick;
        chk("split c5 wvalid", m_wvalid, 1'b1);
        m_wready = 1'b1;
        tick;
        m_awready = 1'b1;
        chk("split c6 bready", m_bready, 1'b1);
        chk("split c6 wvalid", m_wvalid, 1'b0);
        tick;
        chk("split c7 bvalid", r0_bvalid, 1'b1);
        tick;

        // r0 stalls its response while r1 waits.
        m_bresp = 3'b010;
        awvalid[0] = 1'b1; wvalid[0] = 1'b1;
        awaddr[0] = 8'h40; wdata[0] = 32'h55AA55AA; wstrb[0] = 5'h1F; bready[0] = 1'b0;
        tick;
        arvalid[1] = 1'b1; araddr[1] = 8'h44; rready[1] = 1'b1;
        tick;
        awvalid[0] = 1'b0; wvalid[0] = 1'b0;
        tick;
        tick;
        m_bresp = 3'b111;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("stall%0d bvalid", j), r0_bvalid, 1'b1);
            chk($sformatf("stall%0d bresp", j), r0_bresp, 3'b010);
            chk($sformatf("stall%0d r1 arready", j), r1_arready, 1'b0);
            tick;
        end
        bready[0] = 1'b1;
        chk("stall hs bvalid", r0_bvalid, 1'b1);
        chk("stall hs bresp", r0_bresp, 3'b010);
        tick;
        chk("stall gap busy", busy, 1'b0);
        chk("stall gap arready", r1_arready, 1'b0);
        tick;
        chk("stall r1 grant", grant, 1'b1);
        chk("stall r1 arready", r1_arready, 1'b1);
        m_rdata = 32'h0000ABCD; m_rresp = 3'd0;
        tick;
        arvalid[1] = 1'b0;
        tick;
        tick;
        chk("stall r1 rdata", r1_rdata, 32'h0000ABCD);
        tick;

        // Reset in R_RESP drops the read; pending r1 is then granted from IDLE.
        m_rvalid = 1'b0;
        arvalid[0] = 1'b1; araddr[0] = 8'h50; rready = 2'b11;
        tick;
        tick;
        arvalid[0] = 1'b0;
        arvalid[1] = 1'b1; araddr[1] = 8'h5C;
        chk("rr m_araddr", m_araddr, 8'h50);
        tick;
        chk("rr in resp", {busy, m_rready}, 2'b11);
        #2;
        rstn = 1'b0;
        #1;
        chk("rr async m_rready", m_rready, 1'b0);
        chk("rr async busy", busy, 1'b0);
        chk("rr async m_araddr", m_araddr, 8'h00);
        chk("rr async readies", {arready_v, rvalid_v, grant}, 5'b0);
        @(posedge clk);
        #1;
        chk("rr held busy", busy, 1'b0);
        rstn = 1'b1;
        m_rvalid = 1'b1; m_rdata = 32'h5C5C5C5C;
        tick;
        chk("rr r1 grant", grant, 1'b1);
        chk("rr r1 arready", arready_v, 2'b10);
        tick;
        arvalid[1] = 1'b0;
        chk("rr r1 araddr", m_araddr, 8'h5C);
        tick;
        tick;
        chk("rr r1 rvalid", rvalid_v, 2'b10);
        chk("rr r1 rdata", r1_rdata, 32'h5C5C5C5C);
        tick;
        chk("rr idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/axil_rr_arbiter.md
# axil_rr_arbiter

Two-requester AXI-lite arbiter sharing the single AXI-lite slave port of the address-decoding bus between two upstream masters. It accepts one transaction at a time from requester 0 or 1 and replays it on its downstream master port (wired to the bus `s0_*` port). It returns the response to the originating requester. Arbitration is round-robin between requesters, with write/read alternation within each requester.

## Interface
Parameters:
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 8, address width
- RESP_WIDTH, 3, response width
- STRB_WIDTH, DATA_WIDTH/8+1, strobe width, matching the bus port

Ports (N = 0, 1; rN_* is requester N, m_* is downstream). One clock; reset is asynchronous and active-low.
- axi_aclk  in  1  clock
- axi_aresetn  in  1  asynchronous active-low reset
- rN_awaddr, rN_awvalid / rN_awready  in / out  ADDR_WIDTH, 1 / 1  write address
- rN_wdata, rN_wstrb, rN_wvalid / rN_wready  in / out  DATA_WIDTH, STRB_WIDTH, 1 / 1  write data
- rN_bresp, rN_bvalid / rN_bready  out / in  RESP_WIDTH, 1 / 1  write response
- rN_araddr, rN_arvalid / rN_arready  in / out  ADDR_WIDTH, 1 / 1  read address
- rN_rdata, rN_rresp, rN_rvalid / rN_rready  out / in  DATA_WIDTH, RESP_WIDTH, 1 / 1  read data
- m_awaddr, m_awvalid / m_awready  out / in  write address to bus
- m_wdata, m_wstrb, m_wvalid / m_wready  out / in  write data to bus
- m_bresp, m_bvalid / m_bready  in / out  write response from bus
- m_araddr, m_arvalid / m_arready  out / in  read address to bus
- m_rdata, m_rresp, m_rvalid / m_rready  in / out  read data from bus
- busy  out  1  a transaction is in flight (state != IDLE)
- grant  out  1  requester currently owning the port

## Operation
- A write request from N is rN_awvalid && rN_wvalid. A read request is rN_arvalid. Only one transaction is outstanding in the whole block.
- The state machine has these states: IDLE, W_ACC, W_ISSUE, W_RESP, W_RET, R_ACC, R_ISSUE, R_RESP, R_RET.
- IDLE, requester selection:
  - If exactly one requester has a request, it wins.
  - If both have requests, the requester != last_grant wins.
- IDLE, type selection within the winner:
  - If it has both a write and a read request, it gets the type opposite to its last granted type (pref_N).
  - Otherwise it gets whatever it requested.
- On the grant edge: update grant, last_grant and pref_N, then go to W_ACC or R_ACC.
- W_ACC: rN_awready = rN_wready = 1 for the granted N only. On the edge, capture awaddr, wdata and wstrb, then go to W_ISSUE.
- W_ISSUE: m_awvalid = m_wvalid = 1, driven from registers.
  - Each valid drops independently after its own handshake (m_awready, m_wready).
  - Go to W_RESP once both handshakes are complete; they may finish in the same cycle or in different cycles.
- W_RESP: m_bready = 1. On m_bvalid, capture m_bresp and go to W_RET.
- W_RET: rN_bvalid = 1 with the captured bresp. Hold until rN_bready, then go to IDLE.
- Reads mirror writes:
  - R_ACC: rN_arready = 1.
  - R_ISSUE: m_arvalid until m_arready.
  - R_RESP: m_rready = 1; capture m_rdata and m_rresp on m_rvalid.
  - R_RET: rN_rvalid until rN_rready.
- Response codes pass through unmodified; the block never generates errors.
- The non-granted requester sees all readies and valids at 0, and its request stays pending.
- Captured payload is stable for the whole transaction, regardless of requester input changes.

## Timing
- Reset (asynchronous, immediate):
  - State IDLE; last_grant = 1 (so r0 wins first contention).
  - pref_0 = pref_1 = write.
  - All valid/ready outputs 0; all data/resp/addr outputs 0; busy = 0, grant = 0.
- Reset mid-transaction drops the in-flight transaction; downstream valids fall asynchronously.
- Ready/valid outputs are decoded from registered state only, with no combinational path from any input.
- Request edge timing, with the request seen in IDLE at cycle 0:
  - Cycle 1: ACC.
  - Cycle 2: ISSUE.
  - Cycle 3 minimum: RESP (downstream ready in cycle 2).
- Minimum write latency: rN_bvalid in cycle 4 if m_bvalid is present in cycle 3. Reads are the same with rN_rvalid.
- Back-to-back: a new grant is possible in the cycle after the RET handshake, so one idle cycle occurs between transactions.
- Requester valids must remain high until their ACC cycle; this is guaranteed by the AXI rule.

## Test plan
- r0 writes addr 0x04, data 0xDEADBEEF, strb 0x0F; downstream always ready, bresp 0 -> m_awaddr 0x04 and m_wdata 0xDEADBEEF in cycle 2; r0_bvalid=1, bresp=0 in cycle 4; r1 sees no ready.
- r0 and r1 both read from cycle 0 (addr 0x08 and 0x18) -> r0 granted first, r1 second; each rN_rvalid carries its own rdata (0x11111111 and 0x22222222); no cross-delivery.
- r1 holds write and read (aw 0x14, ar 0x1C) continuously with r0 idle -> grants alternate W, R, W, R; busy low exactly one cycle between transactions.
- m_awready in cycle 2, m_wready in cycle 5 -> m_awvalid drops after cycle 2, m_wvalid stays high through cycle 5, W_RESP entered in cycle 6.
- r0_bready held low 3 cycles with r1 requesting -> r0_bvalid and bresp stable; r1 not granted until the cycle after the r0_bready handshake.
- axi_aresetn pulsed low during R_RESP -> all outputs 0 immediately; after release, a pending r1 request is granted fresh from IDLE with r0 priority restored.
